// File: rtl/tetris_pkg.sv
// Shared Tetris playfield definitions: default geometry, row type,
// line-clear FSM states and the line-clear score table.
package tetris_pkg;

  localparam int ROWS_DEF   = 20;
  localparam int COLS_DEF   = 10;
  localparam int ADDR_W_DEF = 5;

  typedef logic [COLS_DEF-1:0] row_t;

  typedef enum logic [2:0] {
    LC_IDLE  = 3'd0,
    LC_READ  = 3'd1,
    LC_CHECK = 3'd2,
    LC_FILL  = 3'd3,
    LC_DONE  = 3'd4
  } lc_state_e;

  // Points awarded for clearing 1, 2, 3 or 4+ lines in one pass.
  localparam logic [15:0] SCORE_1 = 16'd40;
  localparam logic [15:0] SCORE_2 = 16'd100;
  localparam logic [15:0] SCORE_3 = 16'd300;
  localparam logic [15:0] SCORE_4 = 16'd1200;

endpackage

// File: rtl/line_score.sv
// Score accumulator for the line-clear controller: looks up the points for
// the number of lines cleared in a pass and adds them, saturating at 16'hFFFF.
// Only instantiated when LINE_CLEAR_SCORE_EN is defined.
module line_score
  import tetris_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] cnt_i,
  output logic [15:0]       score_o
);

  logic [15:0] score_q;
  logic [15:0] score_d;
  logic [16:0] sum_s;

  function automatic logic [15:0] score_lookup(input logic [ADDR_W-1:0] lines);
    logic [15:0] pts;
    case (lines)
      ADDR_W'(0): pts = 16'd0;
      ADDR_W'(1): pts = SCORE_1;
      ADDR_W'(2): pts = SCORE_2;
      ADDR_W'(3): pts = SCORE_3;
      default:    pts = SCORE_4;
    endcase
    return pts;
  endfunction

  // Saturating add of this pass's points when the pass completes.
  always_comb begin
    sum_s   = {1'b0, score_q} + {1'b0, score_lookup(cnt_i)};
    score_d = score_q;
    if (en_i) begin
      score_d = sum_s[16] ? 16'hFFFF : sum_s[15:0];
    end else begin
      score_d = score_q;
    end
  end

  // Score register, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      score_q <= 16'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the board bottom to top, counts full rows,
// compacts surviving rows downward and zero-fills the vacated top rows.
// Optional score output enabled by defining LINE_CLEAR_SCORE_EN.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [COLS-1:0]   rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [COLS-1:0]   wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [15:0]       score
`endif
);

  localparam logic [ADDR_W-1:0] TOP_ROW  = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_Z   = ADDR_W'(0);

  lc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] lines_q, lines_d;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [COLS-1:0]   wr_data_s;

  // State and pointer registers; reset aborts any pass in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LC_IDLE;
      src_q     <= ADDR_Z;
      dst_q     <= ADDR_Z;
      cnt_q     <= ADDR_Z;
      rd_addr_q <= ADDR_Z;
      lines_q   <= ADDR_Z;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      lines_q   <= lines_d;
    end
  end

  // Next-state logic and write-port decode. Writes are decoded from the
  // registered state and the registered memory read, so they cannot glitch.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    lines_d   = lines_q;
    wr_en_s   = 1'b0;
    wr_addr_s = ADDR_Z;
    wr_data_s = '0;
    case (state_q)
      LC_IDLE: begin
        if (start) begin
          src_d     = TOP_ROW;
          dst_d     = TOP_ROW;
          cnt_d     = ADDR_Z;
          rd_addr_d = TOP_ROW;
          state_d   = LC_READ;
        end else begin
          state_d = LC_IDLE;
        end
      end
      LC_READ: begin
        state_d = LC_CHECK;
      end
      LC_CHECK: begin
        if (&rd_data) begin
          cnt_d = cnt_q + ADDR_ONE;
        end else begin
          // A row already in place needs no rewrite.
          if (dst_q != src_q) begin
            wr_en_s   = 1'b1;
            wr_addr_s = dst_q;
            wr_data_s = rd_data;
          end else begin
            wr_en_s = 1'b0;
          end
          dst_d = dst_q - ADDR_ONE;
        end
        if (src_q == ADDR_Z) begin
          state_d = (cnt_d != ADDR_Z) ? LC_FILL : LC_DONE;
        end else begin
          src_d     = src_q - ADDR_ONE;
          rd_addr_d = src_q - ADDR_ONE;
          state_d   = LC_READ;
        end
      end
      LC_FILL: begin
        wr_en_s   = 1'b1;
        wr_addr_s = dst_q;
        wr_data_s = '0;
        if (dst_q == ADDR_Z) begin
          state_d = LC_DONE;
        end else begin
          dst_d = dst_q - ADDR_ONE;
        end
      end
      LC_DONE: begin
        lines_d = cnt_q;
        state_d = LC_IDLE;
      end
      default: begin
        state_d = LC_IDLE;
      end
    endcase
  end

  assign rd_addr       = rd_addr_q;
  assign wr_en         = wr_en_s;
  assign wr_addr       = wr_addr_s;
  assign wr_data       = wr_data_s;
  assign busy          = (state_q != LC_IDLE);
  assign done          = (state_q == LC_DONE);
  assign lines_cleared = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
  line_score #(
    .ADDR_W (ADDR_W)
  ) u_line_score (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (state_q == LC_DONE),
    .cnt_i   (cnt_q),
    .score_o (score)
  );
`endif

endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
Sequences the Tetris playfield memory after a piece locks. It scans the board rows from bottom to top and detects completed rows. Surviving rows are compacted downward and the vacated top rows are zero-filled. It sits between game_logic, which issues start and holds off board writes while busy, and the row-wide board storage that pixel_driver reads. It reports the number of lines cleared and, optionally, a running score.

Parameters:
ROWS, 20, playfield height in rows; row 0 is the top.
COLS, 10, playfield width; one bit per cell, 1 = occupied.
ADDR_W, 5, row address width; must satisfy 2**ADDR_W >= ROWS.

Ports:
clk  in  1  system clock (MAX10_CLK1_50 domain)
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to run a clear pass; sampled only in IDLE
rd_addr  out  ADDR_W  board read row address
rd_data  in  COLS  board row data; valid exactly 1 cycle after rd_addr
wr_en  out  1  board row write strobe
wr_addr  out  ADDR_W  board write row address
wr_data  out  COLS  board write row data
busy  out  1  high from the cycle after start is accepted until done is asserted inclusive
done  out  1  one-cycle pulse at the end of a pass
lines_cleared  out  ADDR_W  full-row count of the last completed pass; held until the next done

Behaviour:
- Reset: state=IDLE; rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, lines_cleared=0; score=0 when the macro is defined.
- Internal state: src pointer, dst pointer (both ADDR_W bits), cnt (ADDR_W bits).
- FSM states: IDLE, READ, CHECK, FILL, DONE.
- IDLE: on start, load src=ROWS-1, dst=ROWS-1, cnt=0, then go to READ.
- READ: drive rd_addr=src; go to CHECK.
- CHECK (rd_data valid):
  - Full row (&rd_data): cnt++; no write.
  - Non-full row with dst!=src: wr_en=1, wr_addr=dst, wr_data=rd_data; dst--.
  - Non-full row with dst==src: no write (write suppression); dst--.
  - Then: if src==0, go to FILL when cnt>0, else to DONE. Otherwise src--, go to READ.
- FILL: wr_en=1, wr_addr=dst, wr_data=0. When dst==0, go to DONE; else dst--. FILL lasts exactly cnt cycles.
- DONE: done=1, lines_cleared<=cnt, go to IDLE. busy drops the following cycle.
- Latency: start accepted at cycle 0 -> done at cycle 2*ROWS + cnt + 1.
- wr_en is registered-clean, never X, and low in every state except CHECK and FILL.
- start while busy is ignored and not queued.
- Reset mid-pass: aborts immediately to the reset values. The board is left partially compacted; game_logic owns recovery.
- cnt cannot overflow: max ROWS fits in ADDR_W.

Optional Feature:
Macro LINE_CLEAR_SCORE_EN.
- Defined: adds output port score, out, 16 bits.
  - On the DONE cycle, score += table[cnt]: 0->0, 1->40, 2->100, 3->300, >=4->1200.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: port and accumulator are absent; all other behaviour is identical.

Decomposition:
- tetris_pkg holds:
  - ROWS/COLS defaults;
  - typedef row_t (logic [COLS-1:0]);
  - state enum lc_state_e;
  - score table localparams SCORE_1/2/3/4.
- One sub-module is natural: line_score (table lookup plus saturating accumulator). It is instantiated only under LINE_CLEAR_SCORE_EN.
- Full-row detect stays inline.

Test Plan:
- Empty board, start -> no wr_en at all; done at cycle 41; lines_cleared=0; score unchanged.
- Row19=3FF, row18=001, rest 0 -> row19<=001, rows18..1<=0 via shift, row0<=0 via FILL; 20 writes; done at cycle 42; lines_cleared=1; score=40.
- Rows16..19=3FF, row15=155, rest 0 -> row19<=155, rows18..4 shifted, 4 FILL writes rows3..0; lines_cleared=4; score +1200.
- Only row0 full, others 0 -> rows19..1 have no writes (suppression); one FILL write row0<=0; done at cycle 42.
- start pulsed again 10 cycles into a pass -> ignored; exactly one done pulse; latency unchanged.
- All 20 rows full -> 20 FILL writes rows19..0 =0; lines_cleared=20; score +1200. Separately, reset at cycle 15 of a pass -> next cycle busy=0, wr_en=0, done=0, lines_cleared=0.
